// File: rtl/mips_selftest_sequencer.sv
// mips_selftest_sequencer: loads a program image into the MIPS core's instruction memory, runs it and polls one data word for a pass value.
module mips_selftest_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int PROG_DEPTH = 64,
  parameter int ADDR_STEP  = 4,
  parameter int SETTLE     = 8,
  parameter int TIMEOUT    = 1024,
  localparam int LW = $clog2(PROG_DEPTH + 1),
  localparam int IW = $clog2(PROG_DEPTH),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [LW-1:0]         prog_len_in,
  input  logic [ADDR_WIDTH-1:0] check_addr_in,
  input  logic [DATA_WIDTH-1:0] expected_in,
  output logic [IW-1:0]         prog_index_out,
  input  logic [DATA_WIDTH-1:0] prog_word_in,
  output logic                  core_reset_out,
  output logic                  instr_write_out,
  output logic [ADDR_WIDTH-1:0] instr_address_out,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] read_data_address_out,
  input  logic [DATA_WIDTH-1:0] read_data_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  pass_out,
  output logic                  timeout_out,
  output logic                  error_out,
  output logic [CW-1:0]         cycles_out
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [LW-1:0] len, len_n;
  logic [IW-1:0] idx, idx_n;
  logic [ADDR_WIDTH-1:0] chk, chk_n;
  logic [DATA_WIDTH-1:0] exp_q, exp_n;
  logic pass_n, timeout_n, error_n;
  logic [CW-1:0] cyc_n;
  logic can_start, legal, match;
  assign prog_index_out    = idx;
  assign instr_address_out = ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STEP);
  assign instr_out         = instr_write_out ? prog_word_in : '0;
  assign can_start = start_in && (state == IDLE || state == DONE);
  assign legal     = prog_len_in != '0 && prog_len_in <= LW'(PROG_DEPTH);
  // comparison is masked until the pipeline has had time to fill
  assign match     = cycles_out >= CW'(SETTLE) && read_data_in == exp_q;
  always_comb begin
    state_n   = state;
    len_n     = len;
    idx_n     = idx;
    chk_n     = chk;
    exp_n     = exp_q;
    pass_n    = pass_out;
    timeout_n = timeout_out;
    error_n   = error_out;
    cyc_n     = cycles_out;
    if (can_start) begin
      state_n   = legal ? LOAD : DONE;
      len_n     = legal ? prog_len_in : len;
      chk_n     = legal ? check_addr_in : chk;
      exp_n     = legal ? expected_in : exp_q;
      idx_n     = '0;
      pass_n    = 1'b0;
      timeout_n = 1'b0;
      error_n   = !legal;
      cyc_n     = '0;
    end else if (abort_in && (state == LOAD || state == RUN)) begin
      state_n   = IDLE;
      idx_n     = '0;
      pass_n    = 1'b0;
      timeout_n = 1'b0;
      error_n   = 1'b0;
      cyc_n     = '0;
    end else if (state == LOAD) begin
      state_n = LW'(idx) + LW'(1) == len ? RUN : LOAD;
      idx_n   = LW'(idx) + LW'(1) == len ? '0 : idx + IW'(1);
    end else if (state == RUN) begin
      state_n   = match || cycles_out == CW'(TIMEOUT - 1) ? DONE : RUN;
      pass_n    = match;
      timeout_n = !match && cycles_out == CW'(TIMEOUT - 1);
      cyc_n     = match || cycles_out == CW'(TIMEOUT - 1) ? cycles_out : cycles_out + CW'(1);
    end
  end
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state                 <= IDLE;
      len                   <= '0;
      idx                   <= '0;
      chk                   <= '0;
      exp_q                 <= '0;
      core_reset_out        <= 1'b1;
      instr_write_out       <= 1'b0;
      read_data_address_out <= '0;
      busy_out              <= 1'b0;
      done_out              <= 1'b0;
      pass_out              <= 1'b0;
      timeout_out           <= 1'b0;
      error_out             <= 1'b0;
      cycles_out            <= '0;
    end else begin
      state                 <= state_n;
      len                   <= len_n;
      idx                   <= idx_n;
      chk                   <= chk_n;
      exp_q                 <= exp_n;
      core_reset_out        <= state_n != RUN;
      instr_write_out       <= state_n == LOAD;
      read_data_address_out <= (state_n == RUN || state_n == DONE) ? chk_n : '0;
      busy_out              <= state_n == LOAD || state_n == RUN;
      done_out              <= state_n == DONE;
      pass_out              <= pass_n;
      timeout_out           <= timeout_n;
      error_out             <= error_n;
      cycles_out            <= cyc_n;
    end
  end
endmodule

// File: tb/tb_mips_selftest_sequencer.sv
// tb_mips_selftest_sequencer: drives the sequencer with a program store and a data memory that produces the pass word after a chosen run delay.
module tb_mips_selftest_sequencer;
  localparam int DW = 32, AW = 32, PD = 64, AS = 4, ST = 8, TO = 64;
  localparam int LW = $clog2(PD + 1), IW = $clog2(PD), CW = $clog2(TO + 1);
  logic clock_in = 1'b0, reset_in = 1'b0, start_in = 1'b0, abort_in = 1'b0;
  logic [LW-1:0] prog_len_in = '0;
  logic [AW-1:0] check_addr_in = '0;
  logic [DW-1:0] expected_in = '0;
  logic [IW-1:0] prog_index_out;
  logic [DW-1:0] prog_word_in, instr_out, read_data_in;
  logic core_reset_out, instr_write_out, busy_out, done_out, pass_out, timeout_out, error_out;
  logic [AW-1:0] instr_address_out, read_data_address_out;
  logic [CW-1:0] cycles_out;
  int errors = 0, checks = 0;
  logic [DW-1:0] store [PD];
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_word = '0;
  int appear = 1 << 20, run_cnt = 0;

  mips_selftest_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROG_DEPTH(PD), .ADDR_STEP(AS),
    .SETTLE(ST), .TIMEOUT(TO)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in), .abort_in(abort_in),
    .prog_len_in(prog_len_in), .check_addr_in(check_addr_in), .expected_in(expected_in),
    .prog_index_out(prog_index_out), .prog_word_in(prog_word_in), .core_reset_out(core_reset_out),
    .instr_write_out(instr_write_out), .instr_address_out(instr_address_out), .instr_out(instr_out),
    .read_data_address_out(read_data_address_out), .read_data_in(read_data_in), .busy_out(busy_out),
    .done_out(done_out), .pass_out(pass_out), .timeout_out(timeout_out), .error_out(error_out),
    .cycles_out(cycles_out));

  always #5 clock_in = ~clock_in;
  assign prog_word_in = store[prog_index_out];
  // core model: run_cnt counts cycles since the core left reset; the word appears once it reaches appear
  always @(posedge clock_in) run_cnt <= core_reset_out ? 0 : run_cnt + 1;
  assign read_data_in = (read_data_address_out == mem_addr && run_cnt >= appear) ? mem_word : ~mem_word;

  task automatic fill_random();
    for (int i = 0; i < PD; i++) store[i] = $urandom;
  endtask

  task automatic pulse_start(input int len, input logic [AW-1:0] chk, input logic [DW-1:0] expv);
    @(negedge clock_in);
    prog_len_in = LW'(len); check_addr_in = chk; expected_in = expv; start_in = 1'b1;
    @(negedge clock_in);
    start_in = 1'b0; prog_len_in = LW'($urandom); check_addr_in = $urandom; expected_in = $urandom;
  endtask

  task automatic run_case(input int len, input logic [AW-1:0] chk, input logic [DW-1:0] expv, input int app);
    int writes, exp_cyc;
    bit exp_pass, seen;
    mem_addr = chk; mem_word = expv; appear = app;
    pulse_start(len, chk, expv);
    writes = 0;
    for (int i = 0; i < len + 2 && instr_write_out; i++) begin
      checks++;
      if (instr_address_out !== AW'(writes * AS) || instr_out !== store[writes] || core_reset_out !== 1'b1) begin
        errors++;
        $display("FAIL load_write[%0d]: addr=%h data=%h crst=%b, want addr=%h data=%h crst=1",
                 writes, instr_address_out, instr_out, core_reset_out, writes * AS, store[writes]);
      end
      writes++;
      @(negedge clock_in);
    end
    checks++;
    if (writes != len) begin errors++; $display("FAIL load_count: got %0d writes, want %0d", writes, len); end
    checks++;
    if (core_reset_out !== 1'b0 || busy_out !== 1'b1 || read_data_address_out !== chk) begin
      errors++;
      $display("FAIL run_entry: crst=%b busy=%b rda=%h, want crst=0 busy=1 rda=%h", core_reset_out, busy_out, read_data_address_out, chk);
    end
    seen = 0;
    for (int i = 0; i < TO + 8; i++) begin
      if (done_out) begin seen = 1; break; end
      @(negedge clock_in);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_wait: done_out never rose within %0d cycles", TO + 8); end
    exp_cyc = app < ST ? ST : app;
    exp_pass = exp_cyc <= TO - 1;
    if (!exp_pass) exp_cyc = TO - 1;
    checks++;
    if (pass_out !== exp_pass || timeout_out !== !exp_pass || error_out !== 1'b0) begin
      errors++;
      $display("FAIL result(app=%0d): pass=%b timeout=%b error=%b, want pass=%b timeout=%b error=0",
               app, pass_out, timeout_out, error_out, exp_pass, !exp_pass);
    end
    checks++;
    if (cycles_out !== CW'(exp_cyc)) begin
      errors++; $display("FAIL cycles(app=%0d): got %0d, want %0d", app, cycles_out, exp_cyc);
    end
    checks++;
    if (core_reset_out !== 1'b1 || busy_out !== 1'b0 || instr_write_out !== 1'b0 || read_data_address_out !== chk) begin
      errors++;
      $display("FAIL done_state: crst=%b busy=%b wr=%b rda=%h, want crst=1 busy=0 wr=0 rda=%h",
               core_reset_out, busy_out, instr_write_out, read_data_address_out, chk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock_in);
    checks++;
    if (core_reset_out !== 1'b1 || {instr_write_out, busy_out, done_out, pass_out, timeout_out, error_out} !== 6'b0 ||
        cycles_out !== '0 || read_data_address_out !== '0) begin
      errors++; $display("FAIL reset_state: crst=%b wr=%b busy=%b done=%b cycles=%0d, want crst=1 rest 0",
                         core_reset_out, instr_write_out, busy_out, done_out, cycles_out);
    end
    reset_in = 1'b1;
    fill_random();
    pulse_start(10, 32'h40, 32'h1);
    repeat (4) @(negedge clock_in);
    checks++;
    if (prog_index_out !== IW'(4) || instr_write_out !== 1'b1) begin
      errors++; $display("FAIL midload_idx: idx=%0d wr=%b, want idx=4 wr=1", prog_index_out, instr_write_out);
    end
    reset_in = 1'b0;
    @(negedge clock_in);
    checks++;
    if (core_reset_out !== 1'b1 || {instr_write_out, busy_out, done_out, pass_out, timeout_out, error_out} !== 6'b0 ||
        cycles_out !== '0 || prog_index_out !== '0) begin
      errors++; $display("FAIL midload_reset: crst=%b wr=%b busy=%b done=%b idx=%0d, want crst=1 rest 0",
                         core_reset_out, instr_write_out, busy_out, done_out, prog_index_out);
    end
    reset_in = 1'b1;
  endtask

  task automatic test_directed();
    fill_random();
    store[0] = 32'h20080005; store[1] = 32'h20090007; store[2] = 32'h01095020;
    run_case(3, 32'h10, 32'h37, 30);
    fill_random();
    run_case(12, 32'h10, 32'h37, 45);
    run_case(8, 32'h20, 32'hDEADBEEF, 1 << 20);
    run_case(4, 32'h24, 32'h12345678, 0);
    run_case(4, 32'h24, 32'h12345678, ST - 1);
    run_case(PD, 32'h100, 32'hCAFEF00D, TO - 1);
    run_case(1, 32'h8, 32'hA5A5A5A5, TO);
  endtask

  task automatic test_error();
    bit wrote;
    for (int k = 0; k < 2; k++) begin
      pulse_start(k == 0 ? 0 : PD + 1, 32'h4, 32'h5);
      wrote = instr_write_out;
      checks++;
      if (error_out !== 1'b1 || done_out !== 1'b1 || pass_out !== 1'b0 || timeout_out !== 1'b0 || busy_out !== 1'b0) begin
        errors++; $display("FAIL bad_len(k=%0d): err=%b done=%b pass=%b to=%b busy=%b, want err=1 done=1 others 0",
                           k, error_out, done_out, pass_out, timeout_out, busy_out);
      end
      repeat (4) begin @(negedge clock_in); wrote |= instr_write_out; end
      checks++;
      if (wrote !== 1'b0) begin errors++; $display("FAIL bad_len_write(k=%0d): instr_write_out=1, want never", k); end
    end
  endtask

  task automatic test_abort();
    bit seen;
    fill_random();
    mem_addr = 32'h30; mem_word = 32'h77; appear = 1 << 20;
    pulse_start(6, 32'h30, 32'h77);
    @(negedge clock_in);
    abort_in = 1'b1;
    @(negedge clock_in);
    abort_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || instr_write_out !== 1'b0 || core_reset_out !== 1'b1 || done_out !== 1'b0) begin
      errors++; $display("FAIL abort_load: busy=%b wr=%b crst=%b done=%b, want busy=0 wr=0 crst=1 done=0",
                         busy_out, instr_write_out, core_reset_out, done_out);
    end
    pulse_start(5, 32'h30, 32'h77);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (!core_reset_out && cycles_out == CW'(10)) begin start_in = 1'b1; prog_len_in = LW'(3); end
      if (!core_reset_out && cycles_out == CW'(20)) begin seen = 1; break; end
      @(negedge clock_in);
      start_in = 1'b0;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_wait: cycles_out never reached 20 in RUN"); end
    abort_in = 1'b1;
    @(negedge clock_in);
    abort_in = 1'b0;
    checks++;
    if (busy_out !== 1'b0 || pass_out !== 1'b0 || done_out !== 1'b0 || core_reset_out !== 1'b1 || cycles_out !== '0) begin
      errors++; $display("FAIL abort_run: busy=%b pass=%b done=%b crst=%b cycles=%0d, want busy=0 pass=0 done=0 crst=1 cycles=0",
                         busy_out, pass_out, done_out, core_reset_out, cycles_out);
    end
    abort_in = 1'b1;
    @(negedge clock_in);
    abort_in = 1'b0;
    fill_random();
    run_case(7, 32'h30, 32'h77, 15);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_case($urandom_range(1, PD), $urandom & 32'hFFFC, $urandom, $urandom_range(0, TO + 10));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_error();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_selftest_sequencer.md
Name: mips_selftest_sequencer

Overview:
Synthesisable self-test sequencer that lets the pipelined MIPS core run a directed program on-chip without a simulation testbench. It holds the core in reset and streams a program image from an external program store into instruction memory. It then releases the core and polls one data-memory address until an expected value appears or a cycle budget runs out. It sits beside the mips instance and drives its reset_in, instrWrite_in, instr_address_in, instr_in and read_data_address_in, and observes read_data_out.

Parameters:
DATA_WIDTH, 32, instruction and data word width
ADDR_WIDTH, 32, instruction and data address width
PROG_DEPTH, 64, maximum program length in words
ADDR_STEP, 4, address increment per instruction word (byte addressing)
SETTLE, 8, RUN cycles before result comparison is enabled (pipeline fill)
TIMEOUT, 1024, maximum RUN cycles; must satisfy TIMEOUT > SETTLE

Ports:
clock_in  input  1  system clock; the core and instruction memory share it
reset_in  input  1  asynchronous active-low reset
start_in  input  1  one-cycle start request
abort_in  input  1  abandon current LOAD/RUN
prog_len_in  input  $clog2(PROG_DEPTH+1)  words to load; sampled on accepted start
check_addr_in  input  ADDR_WIDTH  data address to poll; sampled on accepted start
expected_in  input  DATA_WIDTH  pass value; sampled on accepted start
prog_index_out  output  $clog2(PROG_DEPTH)  word index requested from program store
prog_word_in  input  DATA_WIDTH  program store word at prog_index_out, same-cycle combinational
core_reset_out  output  1  to core reset_in, 1 = core held in reset
instr_write_out  output  1  instruction memory write enable
instr_address_out  output  ADDR_WIDTH  instruction write address
instr_out  output  DATA_WIDTH  instruction write data
read_data_address_out  output  ADDR_WIDTH  data memory read address
read_data_in  input  DATA_WIDTH  data memory read data, from core read_data_out
busy_out  output  1  high in LOAD or RUN
done_out  output  1  high in DONE
pass_out  output  1  result valid when done_out
timeout_out  output  1  result valid when done_out
error_out  output  1  start rejected because prog_len_in == 0 or prog_len_in > PROG_DEPTH
cycles_out  output  $clog2(TIMEOUT+1)  RUN cycle count

Behaviour:
- Reset (reset_in low, asynchronous): state IDLE, core_reset_out=1, all other outputs 0, internal registers 0.
- IDLE: core_reset_out=1.
  - If start_in=1 and 1<=prog_len_in<=PROG_DEPTH: latch len, check_addr and expected; clear pass, timeout, error and cycles; go to LOAD.
  - If start_in=1 with an illegal length: error_out=1 and go to DONE with pass=0, timeout=0.
- LOAD: core_reset_out=1, instr_write_out=1.
  - Each cycle: instr_address_out = idx*ADDR_STEP, instr_out = prog_word_in, prog_index_out = idx.
  - idx starts at 0 and increments every cycle. LOAD lasts exactly len cycles.
  - After the write with idx==len-1, go to RUN.
  - instr_write_out is 0 in every state other than LOAD.
- RUN: core_reset_out=0, read_data_address_out = latched check_addr.
  - cycles_out is 0 in the first RUN cycle and increments each cycle.
  - When cycles_out >= SETTLE and read_data_in == expected: set pass=1, go to DONE; cycles_out freezes at the matching cycle's value.
  - Otherwise, when cycles_out == TIMEOUT-1: set timeout=1, go to DONE; cycles_out freezes at TIMEOUT-1.
  - If a match and the timeout condition occur in the same cycle, the match wins.
- DONE: core_reset_out=1 (core frozen), read_data_address_out keeps check_addr so memory stays inspectable. Results hold.
  - A start_in in DONE behaves exactly as a start_in in IDLE (DONE is a legal start state).
- abort_in in LOAD or RUN: go to IDLE next edge; core_reset_out=1; results cleared. abort_in has priority over match or timeout in the same cycle.
- start_in while busy is ignored. abort_in in IDLE or DONE is ignored.
- All outputs are registered except prog_index_out, instr_out and instr_address_out, which are combinational from idx and prog_word_in.

Test Plan:
- Reset mid-LOAD (len=10, reset_in low at idx=4) -> next clock core_reset_out=1, instr_write_out=0, state IDLE, every status output 0.
- len=3, store {0x20080005, 0x20090007, 0x01095020}, start -> exactly 3 write cycles to addresses 0x0, 0x4, 0x8 carrying those words in that order; core_reset_out falls the cycle after the third write.
- Fibonacci program, check_addr=0x10, expected=0x37 -> done_out=1, pass_out=1, timeout_out=0, SETTLE<=cycles_out<TIMEOUT.
- expected=0xDEADBEEF never written, TIMEOUT=64 -> done_out=1, pass_out=0, timeout_out=1, cycles_out=63, core_reset_out=1.
- Memory already holds expected at start, SETTLE=8 -> no pass before cycles_out=8; pass_out asserted at cycles_out=8.
- start with prog_len_in=0 -> error_out=1, done_out=1, instr_write_out never asserted. Separately, abort_in during RUN at cycles_out=20 -> IDLE, busy_out=0, pass_out=0; a following start in the same test reloads cleanly.
